ram_arbiter: RTL
================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, RAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 4, RAM data width.
REQ-003 SHALL have ports: clk  in  1  single clock, rising edge; rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have, per requester i in {0,1}: req_valid_i in 1, req_ready_i out 1, req_we_i in 1, req_addr_i in ADDR_WIDTH, req_wdata_i in DATA_WIDTH.
REQ-005 SHALL have, per requester i: rsp_valid_i out 1 (read data valid), rsp_rdata_i out DATA_WIDTH.
REQ-006 SHALL have RAM-side ports: ram_we out 1, ram_addr out ADDR_WIDTH, ram_wdata out DATA_WIDTH, ram_rdata in DATA_WIDTH (synchronous RAM, data valid one cycle after address).
REQ-007 SHALL have busy out 1, high while in INIT.

Function
REQ-008 SHALL implement FSM states INIT and RUN; INIT->RUN after last init write (or immediately, see REQ-021); RUN is terminal until reset.
REQ-009 In RUN, a request SHALL be accepted on a cycle where req_valid_i and req_ready_i are both high; at most one acceptance per cycle.
REQ-010 SHALL drive req_ready_i combinationally: high only for the granted requester in RUN, low for both in INIT.
REQ-011 Arbitration SHALL be round-robin: single requester valid -> granted; both valid -> requester not granted most recently; last-grant pointer resets to 1 (requester 0 wins first tie).
REQ-012 Last-grant pointer SHALL update only on an accepted request.
REQ-013 Accepted request (cycle N) SHALL be registered onto ram_we/ram_addr/ram_wdata in cycle N+1; ram_we SHALL be 0 in every cycle without an accepted write.
REQ-014 Accepted read SHALL produce rsp_valid_i for exactly one cycle at N+3 to its originator, rsp_rdata_i registered from ram_rdata; no response backpressure.
REQ-015 Writes SHALL produce no response.
REQ-016 Back-to-back acceptances SHALL sustain one per cycle; responses SHALL return in acceptance order.
REQ-017 Write to address A at N followed by read of A at N+1 SHALL return the new data.
REQ-018 rsp_rdata_i SHALL hold its last value when rsp_valid_i is low.

Reset
REQ-019 rst high SHALL immediately force: state INIT (or RUN per REQ-021), ram_we 0, ram_addr 0, ram_wdata 0, rsp_valid_i 0, rsp_rdata_i 0, pipeline valids 0, init counter 0, pointer 1.
REQ-020 Reset during INIT or with reads in flight SHALL discard in-flight responses and restart the init sweep from address 0.

Configuration
REQ-021 Macro RAM_ARBITER_INIT_CLEAR_EN: defined -> INIT writes 0 to addresses 0..2^ADDR_WIDTH-1, one per cycle starting the first cycle after reset release, busy high throughout, RUN entered the cycle after the last write; undefined -> reset state is RUN, busy constant 0, no init writes.

Structure
REQ-022 Package ram_arbiter_pkg SHALL hold the state enum (INIT, RUN) and requester-index typedef.
REQ-023 Grant logic SHALL be a sub-module ram_arbiter_rr (two-input round-robin picker, combinational grant, registered pointer).

Verification
REQ-024 Init (macro defined, ADDR_WIDTH 4): release reset -> 16 cycles ram_we 1, ram_addr 0..15, ram_wdata 0, busy low afterwards, req_ready low during.
REQ-025 Single read: requester 0 reads addr 3 after writing 0xA -> rsp_valid_0 at acceptance+3, rsp_rdata_0 = 0xA, rsp_valid_1 stays 0.
REQ-026 Contention: both valid for 4 cycles -> grants alternate 0,1,0,1; responses routed to correct requester.
REQ-027 RAW hazard: requester 1 writes 0x5 to addr 7, next cycle requester 0 reads addr 7 -> rsp_rdata_0 = 0x5.
REQ-028 Reset mid-stream: assert rst one cycle after two reads accepted -> no rsp_valid afterwards, init restarts at addr 0.
REQ-029 Macro undefined: req_ready asserted first cycle after reset release, busy never high.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared types for the two-requester RAM arbiter: FSM state and requester index.
package ram_arbiter_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef logic req_idx_t;

endpackage

// File: rtl/ram_arbiter_rr.sv
// Two-input round-robin picker: combinational grant, registered last-grant pointer.
module ram_arbiter_rr
  import ram_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant,
  output req_idx_t   grant_idx
);

  req_idx_t last_q, last_d;

  always_comb begin
    grant     = 2'b00;
    grant_idx = 1'b0;
    if (en) begin
      if (valid[0] && valid[1]) grant_idx = ~last_q;
      else if (valid[1])        grant_idx = 1'b1;
      else                      grant_idx = 1'b0;
      if (|valid) grant[grant_idx] = 1'b1;
    end
    // A grant is always an acceptance because ready is only raised for a valid requester.
    last_d = (|grant) ? grant_idx : last_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two requesters onto one synchronous RAM; reads respond 3 cycles after acceptance.
// Optional power-up clear sweep of the RAM is enabled by RAM_ARBITER_INIT_CLEAR_EN.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_0,
  output logic                  req_ready_0,
  input  logic                  req_we_0,
  input  logic [ADDR_WIDTH-1:0] req_addr_0,
  input  logic [DATA_WIDTH-1:0] req_wdata_0,
  input  logic                  req_valid_1,
  output logic                  req_ready_1,
  input  logic                  req_we_1,
  input  logic [ADDR_WIDTH-1:0] req_addr_1,
  input  logic [DATA_WIDTH-1:0] req_wdata_1,
  output logic                  rsp_valid_0,
  output logic [DATA_WIDTH-1:0] rsp_rdata_0,
  output logic                  rsp_valid_1,
  output logic [DATA_WIDTH-1:0] rsp_rdata_1,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH:0] INIT_END = {1'b1, {ADDR_WIDTH{1'b0}}};
`ifdef RAM_ARBITER_INIT_CLEAR_EN
  localparam state_e RESET_STATE = INIT;
`else
  localparam state_e RESET_STATE = RUN;
`endif

  state_e                         state_q, state_d;
  logic [ADDR_WIDTH:0]            init_cnt_q, init_cnt_d;
  logic                           ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0]          ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]          ram_wdata_q, ram_wdata_d;
  logic                           p1_valid_q, p1_valid_d;
  req_idx_t                       p1_id_q, p1_id_d;
  logic                           p2_valid_q, p2_valid_d;
  req_idx_t                       p2_id_q, p2_id_d;
  logic [1:0]                     rsp_valid_q, rsp_valid_d;
  logic [1:0][DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;

  logic                  run_en;
  logic [1:0]            grant;
  req_idx_t              acc_idx;
  logic                  accept;
  logic                  acc_we;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;

  assign run_en = (state_q == RUN);

  ram_arbiter_rr u_rr (
    .clk       (clk),
    .rst       (rst),
    .en        (run_en),
    .valid     ({req_valid_1, req_valid_0}),
    .grant     (grant),
    .grant_idx (acc_idx)
  );

  assign req_ready_0 = grant[0];
  assign req_ready_1 = grant[1];
  assign accept      = |grant;
  assign acc_we      = acc_idx ? req_we_1    : req_we_0;
  assign acc_addr    = acc_idx ? req_addr_1  : req_addr_0;
  assign acc_wdata   = acc_idx ? req_wdata_1 : req_wdata_0;

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    p1_valid_d  = 1'b0;
    p1_id_d     = p1_id_q;
    unique case (state_q)
      INIT: begin
        // One extra INIT cycle after the last clear write keeps busy high while it is on the bus.
        if (init_cnt_q == INIT_END) begin
          state_d = RUN;
        end else begin
          ram_we_d    = 1'b1;
          ram_addr_d  = init_cnt_q[ADDR_WIDTH-1:0];
          ram_wdata_d = '0;
          init_cnt_d  = init_cnt_q + (ADDR_WIDTH+1)'(1);
        end
      end
      RUN: begin
        if (accept) begin
          ram_we_d    = acc_we;
          ram_addr_d  = acc_addr;
          ram_wdata_d = acc_wdata;
          p1_valid_d  = !acc_we;
          p1_id_d     = acc_idx;
        end
      end
      default: state_d = RESET_STATE;
    endcase
    // p1: address on RAM; p2: RAM data arriving; then register the response.
    p2_valid_d = p1_valid_q;
    p2_id_d    = p1_id_q;
    for (int i = 0; i < 2; i++) begin
      rsp_valid_d[i] = p2_valid_q && (p2_id_q == req_idx_t'(i));
      rsp_rdata_d[i] = rsp_valid_d[i] ? ram_rdata : rsp_rdata_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RESET_STATE;
      init_cnt_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      p1_valid_q  <= 1'b0;
      p1_id_q     <= 1'b0;
      p2_valid_q  <= 1'b0;
      p2_id_q     <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      p1_valid_q  <= p1_valid_d;
      p1_id_q     <= p1_id_d;
      p2_valid_q  <= p2_valid_d;
      p2_id_q     <= p2_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign rsp_valid_0 = rsp_valid_q[0];
  assign rsp_valid_1 = rsp_valid_q[1];
  assign rsp_rdata_0 = rsp_rdata_q[0];
  assign rsp_rdata_1 = rsp_rdata_q[1];

`ifdef RAM_ARBITER_INIT_CLEAR_EN
  assign busy = (state_q == INIT);
`else
  assign busy = 1'b0;
`endif

endmodule
